// File: rtl/fifo_buffer_ctl_pkg.sv
// Shared FIFO sizing defaults and small helper types.
// Every FIFO user imports this so buffers are sized consistently.
package fifo_buffer_ctl_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 4;
    localparam int DEF_AEMPTY_TH = 2;

    // Default almost-full level: two entries short of a full buffer.
    function automatic int def_afull_th(input int addr_w);
        return (1 << addr_w) - 2;
    endfunction

    // Requests that actually take effect in a given cycle.
    typedef struct packed {
        logic wr;
        logic rd;
    } fifo_op_t;

endpackage

// File: rtl/fifo_buffer_ctl_ram.sv
// FIFO storage: DEPTH x DATA_W array,
// synchronous write port, asynchronous read port.
module fifo_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port: one entry per clock when enabled.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_buffer_ctl.sv
// Synchronous first-word-fall-through FIFO controller with
// occupancy count, thresholds, flush and sticky error flags.
module fifo_buffer_ctl
    import fifo_buffer_ctl_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int AFULL_TH  = def_afull_th(ADDR_W),
    parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              wr,
    input  logic [DATA_W-1:0] din,
    input  logic              rd,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  AF_LVL  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0]  AE_LVL  = CNT_W'(AEMPTY_TH);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    // Reject threshold settings that can never be reached.
    generate
        if (AFULL_TH > DEPTH || AEMPTY_TH >= DEPTH || AFULL_TH < 0 ||
            AEMPTY_TH < 0) begin : g_bad_th
            $error("fifo_buffer_ctl: threshold out of range");
        end
    endgenerate

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  cnt_q;
    fifo_op_t          op;
    logic              ovf_set;
    logic              udf_set;

    assign empty        = (cnt_q == '0);
    assign full         = (cnt_q == CNT_MAX);
    assign almost_full  = (cnt_q >= AF_LVL);
    assign almost_empty = (cnt_q <= AE_LVL);
    assign count        = cnt_q;

    // Effective requests; a write at full needs a paired read,
    // a read at empty is ignored even when a write lands.
    always_comb begin
        op      = '0;
        op.rd   = rd & ~empty;
        op.wr   = wr & (~full | rd);
        ovf_set = ~flush & wr & ~op.wr;
        udf_set = ~flush & rd & ~op.rd;
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (op.wr & ~flush & ~reset),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (dout)
    );

    // Pointer and occupancy update; flush wins over requests.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (op.wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (op.rd) rd_ptr <= rd_ptr + PTR_ONE;
            if (op.wr && !op.rd)
                cnt_q <= cnt_q + CNT_ONE;
            else if (op.rd && !op.wr)
                cnt_q <= cnt_q - CNT_ONE;
        end
    end

    // Sticky error flags; a new error beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set)      overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
            if (udf_set)      underflow <= 1'b1;
            else if (clr_err) underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_buffer_ctl.sv
// Directed and scoreboard checks for fifo_buffer_ctl
// at DEPTH 4, AFULL_TH 3, AEMPTY_TH 1.
module tb_fifo_buffer_ctl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] din = '0;
    logic       rd = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] dout;
    logic       empty, full, almost_empty, almost_full;
    logic [2:0] count;
    logic       overflow, underflow;

    int n_checks = 0;
    int n_errors = 0;

    fifo_buffer_ctl #(
        .DATA_W    (8),
        .ADDR_W    (2),
        .AFULL_TH  (3),
        .AEMPTY_TH (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .wr           (wr),
        .din          (din),
        .rd           (rd),
        .dout         (dout),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the edge.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d,
                       input logic f, input logic c);
        wr = w; rd = r; din = d; flush = f; clr_err = c;
        @(posedge clk);
        #1;
        wr = 0; rd = 0; flush = 0; clr_err = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [7:0] fill_v [4];
    logic [7:0] order_v [4];
    logic [7:0] q [$];
    logic       m_ovf, m_udf, m_wr, m_rd;
    logic       s_wr, s_rd, s_fl, s_ce;
    logic [7:0] s_d;

    initial begin
        fill_v  = '{8'h11, 8'h22, 8'h33, 8'h44};
        order_v = '{8'h22, 8'h33, 8'h44, 8'h66};

        do_reset();
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_aempty", almost_empty, 1);
        check("rst_afull", almost_full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_udf", underflow, 0);

        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, fill_v[i], 0, 0);
            check("fill_count", count, i + 1);
            check("fill_afull", almost_full, (i + 1) >= 3);
            check("fill_aempty", almost_empty, (i + 1) <= 1);
            check("fill_full", full, i == 3);
            check("fill_dout", dout, 8'h11);
            check("fill_empty", empty, 0);
        end

        cyc(1, 0, 8'h55, 0, 0);
        check("ovf_count", count, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_dout", dout, 8'h11);

        cyc(1, 1, 8'h66, 0, 0);
        check("rw_full_count", count, 4);
        check("rw_full_ovf", overflow, 1);
        check("rw_full_dout", dout, 8'h22);

        cyc(0, 0, 0, 0, 1);
        check("clr_ovf", overflow, 0);

        for (int i = 0; i < 4; i++) begin
            check("order_dout", dout, order_v[i]);
            cyc(0, 1, 0, 0, 0);
            check("order_count", count, 3 - i);
        end
        check("drain_empty", empty, 1);
        check("drain_udf", underflow, 0);

        cyc(1, 1, 8'hA5, 0, 0);
        check("rw_empty_count", count, 1);
        check("rw_empty_dout", dout, 8'hA5);
        check("rw_empty_udf", underflow, 1);
        cyc(0, 0, 0, 0, 1);
        check("clr_udf", underflow, 0);
        check("clr_keep_cnt", count, 1);

        cyc(1, 0, 8'hB1, 0, 0);
        cyc(1, 0, 8'hB2, 0, 0);
        check("pre_flush_cnt", count, 3);
        cyc(1, 0, 8'hC3, 1, 0);
        check("flush_count", count, 0);
        check("flush_empty", empty, 1);
        check("flush_ovf", overflow, 0);
        check("flush_udf", underflow, 0);
        cyc(1, 0, 8'h7E, 0, 0);
        check("post_flush_dout", dout, 8'h7E);
        check("post_flush_cnt", count, 1);

        for (int i = 0; i < 3; i++) cyc(1, 0, 8'(i), 0, 0);
        check("refill_full", full, 1);
        cyc(1, 0, 8'h99, 0, 1);
        check("set_wins_ovf", overflow, 1);
        check("set_wins_cnt", count, 4);

        do_reset();
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_afull", almost_full, 0);

        q.delete();
        m_ovf = 0;
        m_udf = 0;
        for (int n = 0; n < 10000; n++) begin
            s_wr = ($urandom_range(0, 99) < 55);
            s_rd = ($urandom_range(0, 99) < 50);
            s_fl = ($urandom_range(0, 99) < 3);
            s_ce = ($urandom_range(0, 99) < 5);
            s_d  = 8'($urandom);
            m_rd = s_rd && (q.size() != 0);
            m_wr = s_wr && ((q.size() != 4) || s_rd);
            if (s_fl) begin
                q.delete();
            end else begin
                if (m_rd) void'(q.pop_front());
                if (m_wr) q.push_back(s_d);
            end
            if (!s_fl && s_wr && !m_wr) m_ovf = 1;
            else if (s_ce) m_ovf = 0;
            if (!s_fl && s_rd && !m_rd) m_udf = 1;
            else if (s_ce) m_udf = 0;
            cyc(s_wr, s_rd, s_d, s_fl, s_ce);
            check("soak_count", count, q.size());
            check("soak_empty", empty, q.size() == 0);
            check("soak_full", full, q.size() == 4);
            check("soak_aempty", almost_empty, q.size() <= 1);
            check("soak_afull", almost_full, q.size() >= 3);
            check("soak_ovf", overflow, m_ovf);
            check("soak_udf", underflow, m_udf);
            if (q.size() != 0) check("soak_dout", dout, q[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
